seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PAT_DEFAULT, default 4'b1011: pattern loaded at reset, PAT_LEN bits wide.
REQ-003 The block SHALL have parameter COUNT_W, default 8: match counter width, legal range 2..16.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port SIn  input  1  serial data bit.
REQ-007 The block SHALL have port en  input  1  SIn valid qualifier; a bit is consumed only on edges with en=1.
REQ-008 The block SHALL have port ovl  input  1  mode: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 The block SHALL have port load  input  1  pattern load strobe.
REQ-010 The block SHALL have port pattern_in  input  PAT_LEN  new pattern, captured when load=1.
REQ-011 The block SHALL have port detected  output  1  registered one-cycle match pulse.
REQ-012 The block SHALL have port match_count  output  COUNT_W  number of matches since reset or last load.
REQ-013 The block SHALL have port cnt_sat  output  1  sticky flag: match_count has saturated.

Function
REQ-014 Consumed bits SHALL shift into history register hist as hist <= {hist[PAT_LEN-2:0], SIn}; the earliest bit of a match compares to pattern[PAT_LEN-1].
REQ-015 Fill counter fill SHALL increment per consumed bit and saturate at PAT_LEN.
REQ-016 A match SHALL occur on an edge with en=1, load=0, where next hist equals pattern and next fill equals PAT_LEN.
REQ-017 detected SHALL be 1 for exactly the cycle following the edge that consumed the final matching bit, else 0; latency 1 clock from the sampling edge.
REQ-018 On a match with ovl=1, fill SHALL remain PAT_LEN, so overlapping matches are reported.
REQ-019 On a match with ovl=0, fill SHALL clear to 0, so the next match needs PAT_LEN fresh bits.
REQ-020 ovl SHALL be sampled per edge; changing it mid-stream SHALL affect only subsequent matches.
REQ-021 On edges with en=0, hist, fill and pattern SHALL hold and detected SHALL be 0.
REQ-022 load=1 SHALL capture pattern_in, clear hist, fill, match_count and cnt_sat, and force detected=0 on the next cycle.
REQ-023 When load and en are both 1 on the same edge, load SHALL win and that SIn bit SHALL be discarded.
REQ-024 match_count SHALL increment by 1 per match and saturate at 2^COUNT_W-1.
REQ-025 cnt_sat SHALL set when a match occurs with match_count already at 2^COUNT_W-1 and SHALL stay set until reset or load.

Reset
REQ-026 While rst=0 at a rising edge, pattern SHALL become PAT_DEFAULT, and hist, fill, detected, match_count and cnt_sat SHALL become 0.
REQ-027 rst=0 SHALL override load and en, including mid-pattern; partial history SHALL be discarded.
REQ-028 The first bit SHALL be consumed on the first edge with rst=1 and en=1.

Configuration
REQ-029 Macro SEQDET_COUNT_EN SHALL control the counter: when defined, match_count and cnt_sat SHALL behave per REQ-024/025.
REQ-030 When SEQDET_COUNT_EN is undefined, no counter logic SHALL be built; match_count and cnt_sat SHALL be constant 0, and ports and detection behaviour SHALL be unchanged.

Verification (PAT_LEN=4, PAT_DEFAULT=1011, en=1 unless stated)
REQ-031 Reset: rst=0 for 3 edges, SIn toggling, load=1 -> detected=0, match_count=0, cnt_sat=0; pattern remains 1011.
REQ-032 Overlap: ovl=1, SIn 1,0,1,1,0,1,1 -> detected pulses after bits 4 and 7; match_count=2.
REQ-033 Non-overlap: ovl=0, SIn 1,0,1,1,0,1,1 -> one pulse after bit 4 only; continue with 1,0,1,1 -> second pulse after bit 11; match_count=2.
REQ-034 Qualifier gap: SIn 1,0, then en=0 for 3 edges with SIn=0, then 1,1 -> pulse after last bit; detected=0 during the gap.
REQ-035 Load mid-stream: after bits 1,0,1, load=1 with pattern_in=0110 and en=1 -> bit dropped, count cleared; SIn 0,1,1,0 -> single pulse after 4th bit; match_count=1.
REQ-036 Saturation (COUNT_W=2, SEQDET_COUNT_EN defined, ovl=1): 4 matches -> match_count=3, cnt_sat=1 after 4th; undefined -> both remain 0 while detected still pulses.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern and overlapping or non-overlapping match modes.
// Optional match counter with a saturation flag, built only when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int unsigned         PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0]  PAT_DEFAULT = 4'b1011,
  parameter int unsigned         COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SIn,
  input  logic               en,
  input  logic               ovl,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern_in,
  output logic               detected,
  output logic [COUNT_W-1:0] match_count,
  output logic               cnt_sat
);

  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_nxt;
  logic               match_c;

  // Look-ahead of the history after this edge's bit; the match is judged on that view.
  always_comb begin
    hist_nxt = {hist[PAT_LEN-2:0], SIn};
    fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    match_c  = en && !load && (hist_nxt == pattern) && (fill_nxt == FILL_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern  <= PAT_DEFAULT;
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (load) begin
      pattern  <= pattern_in;
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (en) begin
      hist     <= hist_nxt;
      // Non-overlapping mode demands a full set of fresh bits after each match.
      fill     <= (match_c && !ovl) ? '0 : fill_nxt;
      detected <= match_c;
    end else begin
      detected <= 1'b0;
    end
  end

`ifdef SEQDET_COUNT_EN
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [COUNT_W-1:0] cnt_q;
  logic               sat_q;

  // Saturating match counter; the sticky flag marks a match lost to saturation.
  always_ff @(posedge clk) begin
    if (!rst || load) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (match_c) begin
      if (cnt_q == CNT_MAX) begin
        sat_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + COUNT_W'(1);
      end
    end
  end

  assign match_count = cnt_q;
  assign cnt_sat     = sat_q;
`else
  assign match_count = '0;
  assign cnt_sat     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param (PAT_LEN=4, pattern 1011, COUNT_W=2).
// Counter expectations collapse to zero when SEQDET_COUNT_EN is undefined.
module tb_seq_detector_param;

  localparam int unsigned PAT_LEN = 4;
  localparam int unsigned COUNT_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               sin;
  logic               en;
  logic               ovl;
  logic               load;
  logic [PAT_LEN-1:0] pattern_in;
  logic               detected;
  logic [COUNT_W-1:0] match_count;
  logic               cnt_sat;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic               r;
    logic               e;
    logic               o;
    logic               l;
    logic               s;
    logic [PAT_LEN-1:0] p;
    logic               det;
    logic [COUNT_W-1:0] cnt;
    logic               sat;
  } vec_t;

  vec_t vecs[$];

  seq_detector_param #(
    .PAT_LEN    (PAT_LEN),
    .PAT_DEFAULT(4'b1011),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SIn        (sin),
    .en         (en),
    .ovl        (ovl),
    .load       (load),
    .pattern_in (pattern_in),
    .detected   (detected),
    .match_count(match_count),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic o, input logic l,
                              input logic s, input logic [PAT_LEN-1:0] p, input logic d,
                              input logic [COUNT_W-1:0] c, input logic st);
    vec_t v;
    v.r = r; v.e = e; v.o = o; v.l = l; v.s = s; v.p = p;
    v.det = d; v.cnt = c; v.sat = st;
    return v;
  endfunction

  function automatic void add(input logic r, input logic e, input logic o, input logic l,
                              input logic s, input logic [PAT_LEN-1:0] p, input logic d,
                              input logic [COUNT_W-1:0] c, input logic st);
    vecs.push_back(mk(r, e, o, l, s, p, d, c, st));
  endfunction

  // Normal consumed bit: rst=1, en=1, no load.
  function automatic void bitv(input logic o, input logic s, input logic d,
                               input logic [COUNT_W-1:0] c, input logic st);
    add(1'b1, 1'b1, o, 1'b0, s, 4'b0000, d, c, st);
  endfunction

  function automatic void rstv();
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [COUNT_W-1:0] want_cnt;
    logic               want_sat;
    rst = v.r; en = v.e; ovl = v.o; load = v.l; sin = v.s; pattern_in = v.p;
    @(posedge clk);
    #1;
`ifdef SEQDET_COUNT_EN
    want_cnt = v.cnt;
    want_sat = v.sat;
`else
    want_cnt = '0;
    want_sat = 1'b0;
`endif
    n_vec++;
    if (detected !== v.det || match_count !== want_cnt || cnt_sat !== want_sat) begin
      n_bad++;
      $display("FAIL %s: det/cnt/sat got %b/%0d/%b want %b/%0d/%b",
               tag, detected, match_count, cnt_sat, v.det, want_cnt, want_sat);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; ovl = 1'b0; load = 1'b0; sin = 1'b0; pattern_in = '0;

    // Reset dominates load/en; pattern must stay 1011 (proved by the overlap run).
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Overlapping: 1011011 -> pulses after bits 4 and 7.
    bitv(1, 1, 0, 0, 0); bitv(1, 0, 0, 0, 0); bitv(1, 1, 0, 0, 0); bitv(1, 1, 1, 1, 0);
    bitv(1, 0, 0, 1, 0); bitv(1, 1, 0, 1, 0); bitv(1, 1, 1, 2, 0);
    rstv();

    // Non-overlapping: 10110111011 -> pulses after bits 4 and 11.
    bitv(0, 1, 0, 0, 0); bitv(0, 0, 0, 0, 0); bitv(0, 1, 0, 0, 0); bitv(0, 1, 1, 1, 0);
    bitv(0, 0, 0, 1, 0); bitv(0, 1, 0, 1, 0); bitv(0, 1, 0, 1, 0); bitv(0, 1, 0, 1, 0);
    bitv(0, 0, 0, 1, 0); bitv(0, 1, 0, 1, 0); bitv(0, 1, 1, 2, 0);
    rstv();

    // Qualifier gap: en=0 bits are ignored, pulse lasts a single cycle.
    bitv(1, 1, 0, 0, 0); bitv(1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
    bitv(1, 1, 0, 0, 0); bitv(1, 1, 1, 1, 0);
    add(1, 0, 1, 0, 1, 4'b0000, 0, 1, 0);
    rstv();

    // Load mid-stream with en=1: bit dropped, count cleared, new pattern 0110.
    bitv(1, 1, 0, 0, 0); bitv(1, 0, 0, 0, 0); bitv(1, 1, 0, 0, 0); bitv(1, 1, 1, 1, 0);
    bitv(1, 1, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(1, 1, 0, 1, 0);
    add(1, 1, 1, 1, 1, 4'b0110, 0, 0, 0);
    bitv(1, 0, 0, 0, 0); bitv(1, 1, 0, 0, 0); bitv(1, 1, 0, 0, 0); bitv(1, 0, 1, 1, 0);
    rstv();

    // Saturation at 3 with the restored default pattern.
    bitv(1, 1, 0, 0, 0); bitv(1, 0, 0, 0, 0); bitv(1, 1, 0, 0, 0); bitv(1, 1, 1, 1, 0);
    bitv(1, 0, 0, 1, 0); bitv(1, 1, 0, 1, 0); bitv(1, 1, 1, 2, 0);
    bitv(1, 0, 0, 2, 0); bitv(1, 1, 0, 2, 0); bitv(1, 1, 1, 3, 0);
    bitv(1, 0, 0, 3, 0); bitv(1, 1, 0, 3, 0); bitv(1, 1, 1, 3, 1);
    bitv(1, 0, 0, 3, 1); bitv(1, 1, 0, 3, 1); bitv(1, 1, 1, 3, 1);
    add(1, 0, 1, 1, 0, 4'b1011, 0, 0, 0);

    // ovl switched mid-stream: overlap still reported, later matches non-overlapping.
    bitv(1, 1, 0, 0, 0); bitv(1, 0, 0, 0, 0); bitv(1, 1, 0, 0, 0); bitv(1, 1, 1, 1, 0);
    bitv(0, 0, 0, 1, 0); bitv(0, 1, 0, 1, 0); bitv(0, 1, 1, 2, 0);
    bitv(0, 0, 0, 2, 0); bitv(0, 1, 0, 2, 0); bitv(0, 1, 0, 2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-pattern must discard partial history: 101, reset, then 1 must not match.
    apply(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0), "seq_rst0");
    apply(mk(1, 1, 1, 0, 1, 4'b0000, 0, 0, 0), "seq_b1");
    apply(mk(1, 1, 1, 0, 0, 4'b0000, 0, 0, 0), "seq_b2");
    apply(mk(1, 1, 1, 0, 1, 4'b0000, 0, 0, 0), "seq_b3");
    apply(mk(0, 1, 1, 1, 1, 4'b0000, 0, 0, 0), "seq_rst_mid");
    apply(mk(1, 1, 1, 0, 1, 4'b0000, 0, 0, 0), "seq_post_rst");
    apply(mk(1, 1, 1, 0, 0, 4'b0000, 0, 0, 0), "seq_f2");
    apply(mk(1, 1, 1, 0, 1, 4'b0000, 0, 0, 0), "seq_f3");
    apply(mk(1, 1, 1, 0, 1, 4'b0000, 1, 1, 0), "seq_f4");
    apply(mk(1, 1, 1, 0, 1, 4'b0000, 0, 1, 0), "seq_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
